// File: rtl/led_fader_pkg.sv
// Shared constants for the LED fader: channel count and the default brightness width.
package led_fader_pkg;

    localparam int unsigned NCHAN     = 8;
    localparam int unsigned MXBRT_DEF = 4;
    localparam logic [MXBRT_DEF-1:0] BMAX = '1;

endpackage

// File: rtl/led_fader_chan.sv
// One fader channel: brightness register with load/decay/clear and its PWM output flop.
module led_fader_chan
    import led_fader_pkg::*;
#(
    parameter int unsigned MXBRT = MXBRT_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable_i,
    input  logic             load_i,
    input  logic             tick_i,
    input  logic [MXBRT-1:0] pwm_i,
    output logic             led_o,
    output logic             lit_c
);

    localparam logic [MXBRT-1:0] BFULL = '1;

    logic [MXBRT-1:0] bright_q, bright_d;
    logic             led_q, led_d;

    // Clear beats load, load beats decay; decay saturates at zero.
    always_comb begin
        bright_d = bright_q;
        if (!enable_i) begin
            bright_d = '0;
        end else if (load_i) begin
            bright_d = BFULL;
        end else if (tick_i && (bright_q != '0)) begin
            bright_d = bright_q - MXBRT'(1);
        end
        led_d = (bright_q == BFULL) || (pwm_i < bright_q);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bright_q <= '0;
            led_q    <= 1'b0;
        end else begin
            bright_q <= bright_d;
            led_q    <= led_d;
        end
    end

    assign led_o = led_q;
    assign lit_c = (bright_q != '0);

endmodule

// File: rtl/led_fader.sv
// Eight-channel LED fader: sampled one-hot pattern loads channels to full, a prescaled tick decays them.
module led_fader
    import led_fader_pkg::*;
#(
    parameter int unsigned MXPRE = 16,
    parameter int unsigned MXBRT = MXBRT_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [NCHAN-1:0] pattern,
    input  logic             enable,
    input  logic [1:0]       decay_rate,
    output logic [NCHAN-1:0] led,
    output logic             glow
);

    localparam int unsigned PW = MXPRE + 1;

    logic [NCHAN-1:0] pat_q;
    logic [MXBRT-1:0] pwm_q;
    logic [MXPRE-1:0] pre_q, pre_d;
    logic [PW-1:0]    pre_sum_c;
    logic             tick_c;
    logic             glow_q;
    logic [NCHAN-1:0] lit_c;

    // Prescaler carry-out is the decay tick; both freeze while disabled.
    always_comb begin
        pre_sum_c = PW'(pre_q) + PW'(decay_rate) + PW'(1);
        tick_c    = enable & pre_sum_c[MXPRE];
        pre_d     = pre_q;
        if (enable) begin
            pre_d = pre_sum_c[MXPRE-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pat_q  <= '0;
            pwm_q  <= '0;
            pre_q  <= '0;
            glow_q <= 1'b0;
        end else begin
            pat_q  <= pattern;
            pwm_q  <= pwm_q + MXBRT'(1);
            pre_q  <= pre_d;
            glow_q <= |lit_c;
        end
    end

    for (genvar g = 0; g < NCHAN; g++) begin : g_chan
        led_fader_chan #(.MXBRT(MXBRT)) u_chan (
            .clock    (clock),
            .reset_n  (reset_n),
            .enable_i (enable),
            .load_i   (pat_q[g]),
            .tick_i   (tick_c),
            .pwm_i    (pwm_q),
            .led_o    (led[g]),
            .lit_c    (lit_c[g])
        );
    end

    assign glow = glow_q;

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader: cycle model feeding a scoreboard plus directed latency/fade/enable checks.
module tb_led_fader;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] pattern;
    logic       enable;
    logic [1:0] decay_rate;
    logic [7:0] led;
    logic       glow;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    led_fader #(.MXPRE(4), .MXBRT(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .pattern    (pattern),
        .enable     (enable),
        .decay_rate (decay_rate),
        .led        (led),
        .glow       (glow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model of the fader behaviour, one step per rising edge.
    logic [3:0] m_pre, m_pwm;
    logic [7:0] m_pat;
    logic [3:0] m_br   [8];
    logic [3:0] m_br_n [8];
    logic [4:0] m_sum;
    logic       m_tick;
    logic [7:0] m_led_n;
    logic       m_glow_n;
    logic [8:0] sb [$];

    always_comb begin
        m_sum    = {1'b0, m_pre} + {3'b000, decay_rate} + 5'd1;
        m_tick   = enable && m_sum[4];
        m_led_n  = '0;
        m_glow_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_led_n[i] = (m_br[i] == 4'hF) || (m_pwm < m_br[i]);
            m_glow_n   = m_glow_n | (m_br[i] != 4'h0);
            if (!enable)                        m_br_n[i] = 4'h0;
            else if (m_pat[i])                  m_br_n[i] = 4'hF;
            else if (m_tick && m_br[i] != 4'h0) m_br_n[i] = m_br[i] - 4'h1;
            else                                m_br_n[i] = m_br[i];
        end
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_pre <= '0;
            m_pwm <= '0;
            m_pat <= '0;
            for (int i = 0; i < 8; i++) m_br[i] <= '0;
            sb.delete();
        end else begin
            m_pat <= pattern;
            m_pwm <= m_pwm + 4'h1;
            if (enable) m_pre <= m_sum[3:0];
            for (int i = 0; i < 8; i++) m_br[i] <= m_br_n[i];
            sb.push_back({m_led_n, m_glow_n});
        end
    end

    always @(negedge clock) begin
        if (sb.size() > 0) begin
            logic [8:0] e;
            e = sb.pop_front();
            chk("sb_led_glow", 32'({led, glow}), 32'(e));
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        pattern = 8'h00;
        cyc();
        cyc();
        reset_n = 1'b1;
    endtask

    task automatic count_glow(output int n);
        n = 0;
        while (glow && n < 400) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        int n;
        int bad;
        reset_n    = 1'b0;
        pattern    = 8'hFF;
        enable     = 1'b1;
        decay_rate = 2'd0;

        repeat (3) begin
            cyc();
            chk("rst_led", 32'(led), 32'h0);
            chk("rst_glow", 32'(glow), 32'h0);
        end
        reset_n = 1'b1;
        cyc(); chk("rel_e1", 32'(led), 32'h00);
        cyc(); chk("rel_e2", 32'(led), 32'h00);
        cyc(); chk("rel_e3", 32'(led), 32'hFF);
        chk("rel_glow", 32'(glow), 32'h1);

        // Latency and full fade, decay_rate 0: ticks at edges 16,32,..,240 after release.
        do_reset();
        pattern = 8'h01;
        cyc(); pattern = 8'h00;
        chk("post_rst_glow", 32'(glow), 32'h0);
        chk("lat_e1", 32'(led[0]), 32'h0);
        cyc(); chk("lat_e2", 32'(led[0]), 32'h0);
        cyc(); chk("lat_e3", 32'(led[0]), 32'h1);
        chk("lat_glow", 32'(glow), 32'h1);
        count_glow(n);
        chk("fade_len", 32'(n), 32'd238);
        chk("fade_dark", 32'(led), 32'h0);

        // Fast fade, decay_rate 3: ticks every 4 clocks, 15 ticks from edge 4.
        do_reset();
        decay_rate = 2'd3;
        pattern    = 8'h01;
        cyc(); pattern = 8'h00;
        cyc();
        cyc(); chk("rate_e3", 32'(led[0]), 32'h1);
        count_glow(n);
        chk("rate_len", 32'(n), 32'd58);
        bad = 0;
        repeat (40) begin
            cyc();
            if (led != 8'h00 || glow) bad++;
        end
        chk("no_wrap", 32'(bad), 32'd0);

        // Held pattern bit across many ticks keeps full duty.
        pattern = 8'h04;
        repeat (3) cyc();
        bad = 0;
        repeat (40) begin
            cyc();
            if (!led[2]) bad++;
        end
        chk("hold_led", 32'(bad), 32'd0);
        pattern = 8'h00;

        // Cylon sweep, then drop enable while still lit.
        for (int s = 0; s < 14; s++) begin
            int idx;
            idx     = (s < 8) ? s : 14 - s;
            pattern = 8'(1 << idx);
            repeat (8) cyc();
        end
        chk("sweep_glow", 32'(glow), 32'h1);
        enable = 1'b0;
        cyc();
        cyc();
        chk("drop_led", 32'(led), 32'h0);
        chk("drop_glow", 32'(glow), 32'h0);
        repeat (20) cyc();
        chk("off_led", 32'(led), 32'h0);

        @(negedge clock);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
